// File: rtl/output_tick_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : output_tick_collector_if
// Brief    : Readout stream (valid/ready/last) carrying spike-bitmap words.
// Revision : 1.0
// ============================================================================
interface output_tick_collector_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_last;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/output_tick_collector.sv
`default_nettype none
// ============================================================================
// Module   : output_tick_collector
// Brief    : Runs one SNN tick, gathers output spikes into a bitmap until the
//            bus goes quiet (or times out), then streams the bitmap out.
// Revision : 1.0
// ============================================================================
module output_tick_collector #(
    parameter int NUM_OUTPUTS = 256,
    parameter int WORD_WIDTH  = 32,
    parameter int IDLE_CYCLES = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_start,
    output logic                           tick_out,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] packet_in,
    input  logic                           packet_in_valid,
    output logic                           busy,
    output_tick_collector_if.master        rd,
    output logic [15:0]                    tick_count,
    output logic                           late_packet_error,
    output logic                           timeout_error,
    input  logic                           error_clear
);

    localparam int c_NUM_WORDS = NUM_OUTPUTS / WORD_WIDTH;
    localparam int c_IDX_W     = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
    localparam int c_QUIET_W   = $clog2(IDLE_CYCLES);
    localparam int c_TO_W      = $clog2(TIMEOUT);

    localparam logic [c_IDX_W-1:0]   c_LAST_IDX   = c_IDX_W'(c_NUM_WORDS - 1);
    localparam logic [c_QUIET_W-1:0] c_QUIET_LAST = c_QUIET_W'(IDLE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_TICK    = 2'd1;
    localparam logic [1:0] c_ST_COLLECT = 2'd2;
    localparam logic [1:0] c_ST_READOUT = 2'd3;

    logic [1:0]             r_state;
    logic [NUM_OUTPUTS-1:0] r_bitmap;
    logic [c_IDX_W-1:0]     r_word_idx;
    logic [c_QUIET_W-1:0]   r_quiet;
    logic [c_TO_W-1:0]      r_timeout;
    logic [15:0]            r_tick_count;
    logic                   r_late_err;
    logic                   r_timeout_err;

    logic [WORD_WIDTH-1:0]  w_words [c_NUM_WORDS];
    logic                   w_recording;
    logic                   w_pkt_rec;
    logic                   w_late_set;
    logic                   w_drain;
    logic                   w_to_hit;
    logic                   w_to_set;
    logic                   w_fire;

    generate
        for (genvar g = 0; g < c_NUM_WORDS; g++) begin : g_words
            assign w_words[g] = r_bitmap[g*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign w_recording = (r_state == c_ST_TICK) || (r_state == c_ST_COLLECT);
    assign w_pkt_rec   = packet_in_valid && w_recording;
    assign w_late_set  = packet_in_valid && !w_recording;
    assign w_drain     = (r_state == c_ST_COLLECT) && !packet_in_valid
                         && (r_quiet == c_QUIET_LAST);
    assign w_to_hit    = (r_state == c_ST_COLLECT) && (r_timeout == c_TO_LAST);
    // Drain wins a tie with the timeout, so no error is flagged then.
    assign w_to_set    = w_to_hit && !w_drain;
    assign w_fire      = (r_state == c_ST_READOUT) && rd.rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_bitmap      <= '0;
            r_word_idx    <= '0;
            r_quiet       <= '0;
            r_timeout     <= '0;
            r_tick_count  <= '0;
            r_late_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (tick_start) begin
                        r_state <= c_ST_TICK;
                    end
                end
                c_ST_TICK: begin
                    r_quiet   <= '0;
                    r_timeout <= '0;
                    r_state   <= c_ST_COLLECT;
                end
                c_ST_COLLECT: begin
                    r_timeout <= r_timeout + 1'b1;
                    if (packet_in_valid) begin
                        r_quiet <= '0;
                    end else begin
                        r_quiet <= r_quiet + 1'b1;
                    end
                    if (w_drain || w_to_hit) begin
                        r_state <= c_ST_READOUT;
                    end
                end
                default: begin
                    if (w_fire) begin
                        // Clearing on read leaves the bitmap empty for the next tick.
                        for (int w = 0; w < c_NUM_WORDS; w++) begin
                            if (r_word_idx == c_IDX_W'(w)) begin
                                r_bitmap[w*WORD_WIDTH +: WORD_WIDTH] <= '0;
                            end
                        end
                        if (r_word_idx == c_LAST_IDX) begin
                            r_word_idx   <= '0;
                            r_tick_count <= r_tick_count + 16'd1;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
            endcase

            if (w_pkt_rec) begin
                r_bitmap[packet_in] <= 1'b1;
            end

            if (w_late_set) begin
                r_late_err <= 1'b1;
            end else if (error_clear) begin
                r_late_err <= 1'b0;
            end

            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (error_clear) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign tick_out          = (r_state == c_ST_TICK);
    assign busy              = (r_state != c_ST_IDLE);
    assign rd.rd_valid       = (r_state == c_ST_READOUT);
    assign rd.rd_data        = w_words[r_word_idx];
    assign rd.rd_last        = (r_state == c_ST_READOUT) && (r_word_idx == c_LAST_IDX);
    assign tick_count        = r_tick_count;
    assign late_packet_error = r_late_err;
    assign timeout_error     = r_timeout_err;

endmodule
`default_nettype wire
